muldiv_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 21 ++
 rtl/muldiv_unit.sv | 134 +++++++++++++
 tb/tb_muldiv_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage definitions: ALU/muldiv control codes and the
// muldiv sequencer states.
package mips_pkg;

   typedef enum logic [3:0] {
      CTRL_MULU = 4'b1100,
      CTRL_DIVU = 4'b1101,
      CTRL_MUL  = 4'b1110,
      CTRL_DIV  = 4'b1111
   } ctrl_t;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } md_state_t;

   localparam int MD_ITERS = 32;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide beside the ALU: radix-2 shift-add multiply and
// restoring divide, one bit per clock, results presented on HI/LO after done.
module muldiv_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       control,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int W2 = 2 * WIDTH;

   md_state_t        state;
   ctrl_t            ctrl_q;
   logic [5:0]       cnt;
   logic [W2-1:0]    acc;
   logic [WIDTH-1:0] dsor;
   logic             sign_a;
   logic             sign_b;

   logic             accept;
   logic             div_zero;
   logic             is_div;
   logic [WIDTH-1:0] in1_mag;
   logic [WIDTH-1:0] in2_mag;
   logic [WIDTH:0]   add_a;
   logic [WIDTH:0]   add_r;
   logic [W2-1:0]    acc_step;

   function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                            input logic en);
      return (en && (v < 0)) ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                 input logic en);
      return en ? ((~v) + WIDTH'(1)) : v;
   endfunction

   // acc holds {remainder, quotient} for divide and {product_hi, multiplier} for
   // multiply; dsor holds the divisor or multiplicand magnitude.
   always_comb begin
      in1_mag  = mag(in1, control[1]);
      in2_mag  = mag(in2, control[1]);
      accept   = start && (control[3:2] == 2'b11) && ((state == IDLE) || (state == DONE));
      div_zero = control[0] && (in2 == '0);
      is_div   = (ctrl_q == CTRL_DIVU) || (ctrl_q == CTRL_DIV);
      add_a    = is_div ? {acc[W2-1:WIDTH], acc[WIDTH-1]} : {1'b0, acc[W2-1:WIDTH]};
      add_r    = is_div ? (add_a - {1'b0, dsor}) : (add_a + {1'b0, dsor});
      acc_step = acc;
      if (is_div) begin
         acc_step = add_r[WIDTH] ? {add_a[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                 : {add_r[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         acc_step = acc[0] ? {add_r, acc[WIDTH-1:1]}
                           : {1'b0, acc[W2-1:WIDTH], acc[WIDTH-1:1]};
      end
   end

   // Sequencer and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == DONE) begin
            done <= 1'b1;
            hi   <= acc[W2-1:WIDTH];
            lo   <= acc[WIDTH-1:0];
         end
         if (accept) begin
            cnt         <= '0;
            div_by_zero <= div_zero;
            busy        <= !div_zero;
            state       <= div_zero ? DONE : CALC;
         end else begin
            case (state)
               CALC: begin
                  cnt <= cnt + 6'd1;
                  if (cnt == 6'(MD_ITERS - 1))
                     state <= FIX;
               end
               FIX: begin
                  busy  <= 1'b0;
                  state <= DONE;
               end
               DONE:    state <= IDLE;
               default: ;
            endcase
         end
      end
   end

   // Datapath: operand capture, one iteration per CALC cycle, sign fix-up
   always_ff @(posedge clk) begin
      if (accept) begin
         ctrl_q <= ctrl_t'(control);
         sign_a <= control[1] & in1[WIDTH-1];
         sign_b <= control[1] & in2[WIDTH-1];
         dsor   <= control[0] ? in2_mag : in1_mag;
         if (div_zero)
            acc <= {in1, {WIDTH{1'b1}}};
         else if (control[0])
            acc <= {{WIDTH{1'b0}}, in1_mag};
         else
            acc <= {{WIDTH{1'b0}}, in2_mag};
      end else if (state == CALC) begin
         acc <= acc_step;
      end else if (state == FIX) begin
         if (is_div)
            acc <= {cond_neg(acc[W2-1:WIDTH], sign_a),
                    cond_neg(acc[WIDTH-1:0], sign_a ^ sign_b)};
         else if (sign_a ^ sign_b)
            acc <= -acc;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a result scoreboard and an
// independent arithmetic reference for the randomised operations.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  control;
   logic [31:0] in1;
   logic [31:0] in2;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_by_zero;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .control     (control),
      .in1         (in1),
      .in2         (in2),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      exp_t        r;
      logic [63:0] p;
      p     = '0;
      r.dbz = 1'b0;
      case (c)
         4'b1100: p = {32'h0, a} * {32'h0, b};
         4'b1110: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
         4'b1101: begin
            if (b == 32'h0) begin
               p     = {a, 32'hFFFFFFFF};
               r.dbz = 1'b1;
            end else begin
               p = {a % b, a / b};
            end
         end
         default: begin
            if (b == 32'h0) begin
               p     = {a, 32'hFFFFFFFF};
               r.dbz = 1'b1;
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
               p = {32'h0, 32'h80000000};
            end else begin
               p = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            end
         end
      endcase
      r.hi = p[63:32];
      r.lo = p[31:0];
      return r;
   endfunction

   task automatic push(input logic [31:0] h, input logic [31:0] l, input logic d);
      exp_t e;
      e.hi  = h;
      e.lo  = l;
      e.dbz = d;
      sb.push_back(e);
   endtask

   // Leaves the bench 1 time unit after the accepting edge (edge 0).
   task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start   = 1'b1;
      control = c;
      in1     = a;
      in2     = b;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_n);
      int   n   = 0;
      bit   got = 1'b0;
      exp_t e;
      while (n < 200 && !got) begin
         @(posedge clk);
         #1;
         n++;
         got = done;
      end
      chk({tag, "_latency"}, 64'(n), 64'(exp_n));
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
         chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
         chk({tag, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
         chk({tag, "_busy"}, 64'(busy), 64'(0));
      end else begin
         chk({tag, "_scoreboard"}, 64'(0), 64'(1));
      end
   endtask

   task automatic quiet(input string tag, input int cycles);
      int hits = 0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
         if (done || busy) hits++;
      end
      chk(tag, 64'(hits), 64'(0));
   endtask

   initial begin
      logic [3:0]  ops[4];
      logic [31:0] a;
      logic [31:0] b;
      ops = '{4'b1100, 4'b1101, 4'b1110, 4'b1111};
      rst_n   = 1'b0;
      start   = 1'b0;
      control = 4'b0000;
      in1     = '0;
      in2     = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_hilo", {hi, lo}, 64'h0);
      chk("reset_flags", 64'({busy, done, div_by_zero}), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      push(32'hFFFFFFFE, 32'h00000001, 1'b0);
      issue(4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF);
      chk("umul_busy", 64'(busy), 64'(1));
      wait_done("umul", 34);
      @(posedge clk);
      #1;
      chk("umul_pulse", 64'(done), 64'(0));
      chk("umul_hold", {hi, lo}, 64'hFFFFFFFE_00000001);

      push(32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
      issue(4'b1110, 32'hFFFFFFFD, 32'h00000005);
      wait_done("smul", 34);

      push(32'h00000002, 32'h0000000E, 1'b0);
      issue(4'b1101, 32'h00000064, 32'h00000007);
      wait_done("divu", 34);

      push(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      issue(4'b1111, 32'hFFFFFFF9, 32'h00000002);
      wait_done("sdiv", 34);

      push(32'h00000000, 32'h80000000, 1'b0);
      issue(4'b1111, 32'h80000000, 32'hFFFFFFFF);
      wait_done("sdiv_ovf", 34);

      push(32'h12345678, 32'hFFFFFFFF, 1'b1);
      issue(4'b1101, 32'h12345678, 32'h00000000);
      wait_done("div0", 1);

      a = $urandom;
      b = $urandom;
      sb.push_back(model(4'b1100, a, b));
      issue(4'b1100, a, b);
      chk("dbz_clear", 64'(div_by_zero), 64'(0));
      wait_done("after_div0", 34);

      a = $urandom;
      b = $urandom;
      sb.push_back(model(4'b1110, a, b));
      issue(4'b1110, a, b);
      repeat (9) @(posedge clk);
      @(negedge clk);
      start   = 1'b1;
      control = 4'b1101;
      in1     = 32'h0000BEEF;
      in2     = 32'h0;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("busy_start", 24);
      quiet("busy_start_extra", 40);

      @(negedge clk);
      start   = 1'b1;
      control = 4'b0010;
      in1     = 32'h11111111;
      in2     = 32'h22222222;
      @(posedge clk);
      #1;
      start = 1'b0;
      quiet("alu_code", 40);

      a = $urandom;
      b = $urandom | 32'h1;
      sb.push_back(model(4'b1111, a, b));
      issue(4'b1111, a, b);
      wait_done("b2b_first", 34);
      a = $urandom;
      b = $urandom;
      sb.push_back(model(4'b1100, a, b));
      issue(4'b1100, a, b);
      wait_done("b2b_second", 34);

      issue(4'b1100, 32'hDEADBEEF, 32'h12345678);
      repeat (15) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_hilo", {hi, lo}, 64'h0);
      chk("abort_flags", 64'({busy, done, div_by_zero}), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      quiet("abort_no_done", 40);

      for (int i = 0; i < 6; i++) begin
         a = $urandom;
         b = $urandom;
         if (b == 32'h0) b = 32'h3;
         sb.push_back(model(ops[i % 4], a, b));
         issue(ops[i % 4], a, b);
         wait_done($sformatf("rand%0d", i), 34);
      end

      chk("scoreboard_drained", 64'(sb.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
